// File: rtl/var_stats_stream.sv
// Streaming mean / E[x^2] / variance over LANES*BEATS signed Q8.8 samples.
// Results are Q16.16, queued in a fall-through FIFO whose space is guarded by credits.
module var_stats_stream #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 16,
  parameter int BEATS      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_mean,
  output logic [31:0]             out_ex2,
  output logic [31:0]             out_var,
  output logic                    out_err
);
  localparam int LG_L = $clog2(LANES);
  localparam int LG_B = $clog2(BEATS);
  localparam int LG_N = LG_L + LG_B;
  localparam int BCW  = (LG_B > 0) ? LG_B : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int SQ_W = 2 * DATA_W;
  localparam int TX_W = DATA_W + LG_L;
  localparam int TQ_W = SQ_W + LG_L;
  localparam int AX_W = DATA_W + LG_N;
  localparam int AQ_W = SQ_W + LG_N;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [CW-1:0]  DEPTH     = CW'(FIFO_DEPTH);

  // A full-range negative square still fits as a non-negative 2*DATA_W value.
  function automatic logic [SQ_W-1:0] square(input logic signed [DATA_W-1:0] x);
    logic signed [SQ_W-1:0] xe;
    xe = SQ_W'(x);
    return $unsigned(xe * xe);
  endfunction

  function automatic logic signed [31:0] mean_q16(input logic signed [AX_W-1:0] s);
    logic signed [AX_W+7:0] t;
    t = {s, 8'd0};
    return 32'(t >>> LG_N);
  endfunction

  function automatic logic [31:0] mean_sq(input logic signed [31:0] m);
    logic signed [63:0] me;
    logic signed [63:0] p;
    me = 64'(m);
    p  = me * me;
    return 32'(p >> 16);
  endfunction

  // Floor on the mean can push mean^2 slightly above E[x^2]; clamp at zero.
  function automatic logic [31:0] clamp_var(input logic [31:0] ex2, input logic [31:0] msq);
    logic signed [32:0] d;
    d = $signed({1'b0, ex2}) - $signed({1'b0, msq});
    return d[32] ? 32'd0 : d[31:0];
  endfunction

  logic [BCW-1:0] beat_cnt;
  logic [CW-1:0]  credits;
  logic [PW:0]    wr_ptr;
  logic [PW:0]    rd_ptr;
  logic           accept;
  logic           pop;
  logic           first;
  logic           close;
  logic           err;

  assign in_ready  = (credits != '0) || (beat_cnt != '0);
  assign accept    = in_valid && in_ready;
  assign first     = (beat_cnt == '0);
  assign close     = in_last || (beat_cnt == LAST_BEAT);
  assign err       = in_last != (beat_cnt == LAST_BEAT);
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      credits  <= DEPTH;
    end else begin
      if (accept) beat_cnt <= close ? '0 : beat_cnt + 1'b1;
      case ({accept && first, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
    end
  end

  // ---- S0: samples and squares ----
  logic signed [DATA_W-1:0] x_p0 [LANES];
  logic [SQ_W-1:0]          sq_p0 [LANES];
  logic                     vld_p0;
  logic [2:0]               ctl_p0;

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    ctl_p0 <= {first, close, err};
    for (int k = 0; k < LANES; k++) begin
      x_p0[k]  <= in_data[k*DATA_W +: DATA_W];
      sq_p0[k] <= square(in_data[k*DATA_W +: DATA_W]);
    end
  end

  // ---- Tree: pairwise adders, one bit of growth per stage ----
  for (genvar s = 0; s < LG_L; s++) begin : g_tree
    localparam int NO = LANES >> (s + 1);
    localparam int OX = DATA_W + s + 1;
    localparam int OQ = SQ_W + s + 1;
    logic signed [OX-2:0] ix [2*NO];
    logic [OQ-2:0]        iq [2*NO];
    logic                 iv;
    logic [2:0]           ic;
    logic signed [OX-1:0] sx [NO];
    logic [OQ-1:0]        sq [NO];
    logic                 vld;
    logic [2:0]           ctl;

    if (s == 0) begin : g_in
      assign ix = x_p0;
      assign iq = sq_p0;
      assign iv = vld_p0;
      assign ic = ctl_p0;
    end else begin : g_in
      assign ix = g_tree[s-1].sx;
      assign iq = g_tree[s-1].sq;
      assign iv = g_tree[s-1].vld;
      assign ic = g_tree[s-1].ctl;
    end

    always_ff @(posedge clk) begin
      if (rst) vld <= 1'b0;
      else     vld <= iv;
    end

    always_ff @(posedge clk) begin
      ctl <= ic;
      for (int k = 0; k < NO; k++) begin
        sx[k] <= OX'(ix[2*k]) + OX'(ix[2*k+1]);
        sq[k] <= OQ'(iq[2*k]) + OQ'(iq[2*k+1]);
      end
    end
  end

  logic signed [TX_W-1:0] tx;
  logic [TQ_W-1:0]        tq;
  logic                   tv;
  logic [2:0]             tc;

  if (LG_L == 0) begin : g_tout
    assign tx = x_p0[0];
    assign tq = sq_p0[0];
    assign tv = vld_p0;
    assign tc = ctl_p0;
  end else begin : g_tout
    assign tx = g_tree[LG_L-1].sx[0];
    assign tq = g_tree[LG_L-1].sq[0];
    assign tv = g_tree[LG_L-1].vld;
    assign tc = g_tree[LG_L-1].ctl;
  end

  // ---- P1: per-vector accumulation, restarted by the first beat ----
  logic signed [AX_W-1:0] sum_x_p1;
  logic [AQ_W-1:0]        sum_sq_p1;
  logic                   vld_p1;
  logic                   err_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= tv && tc[1];
  end

  always_ff @(posedge clk) begin
    if (tv) begin
      sum_x_p1  <= tc[2] ? AX_W'(tx) : sum_x_p1 + AX_W'(tx);
      sum_sq_p1 <= tc[2] ? AQ_W'(tq) : sum_sq_p1 + AQ_W'(tq);
      err_p1    <= tc[0];
    end
  end

  // ---- P2: divide by N ----
  logic signed [31:0] mean_p2;
  logic [31:0]        ex2_p2;
  logic               vld_p2;
  logic               err_p2;

  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    mean_p2 <= mean_q16(sum_x_p1);
    ex2_p2  <= 32'(sum_sq_p1 >> LG_N);
    err_p2  <= err_p1;
  end

  // ---- P3: mean squared ----
  logic signed [31:0] mean_p3;
  logic [31:0]        ex2_p3;
  logic [31:0]        msq_p3;
  logic               vld_p3;
  logic               err_p3;

  always_ff @(posedge clk) begin
    if (rst) vld_p3 <= 1'b0;
    else     vld_p3 <= vld_p2;
  end

  always_ff @(posedge clk) begin
    mean_p3 <= mean_p2;
    ex2_p3  <= ex2_p2;
    msq_p3  <= mean_sq(mean_p2);
    err_p3  <= err_p2;
  end

  // ---- P4: subtract and push into the result FIFO ----
  logic [31:0] fifo_mean [FIFO_DEPTH];
  logic [31:0] fifo_ex2  [FIFO_DEPTH];
  logic [31:0] fifo_var  [FIFO_DEPTH];
  logic        fifo_err  [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (vld_p3) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p3) begin
      fifo_mean[wr_ptr[PW-1:0]] <= mean_p3;
      fifo_ex2[wr_ptr[PW-1:0]]  <= ex2_p3;
      fifo_var[wr_ptr[PW-1:0]]  <= clamp_var(ex2_p3, msq_p3);
      fifo_err[wr_ptr[PW-1:0]]  <= err_p3;
    end
  end

  // Outputs read zero whenever the FIFO is empty, so stale entries never show.
  assign out_mean = out_valid ? fifo_mean[rd_ptr[PW-1:0]] : '0;
  assign out_ex2  = out_valid ? fifo_ex2[rd_ptr[PW-1:0]]  : '0;
  assign out_var  = out_valid ? fifo_var[rd_ptr[PW-1:0]]  : '0;
  assign out_err  = out_valid && fifo_err[rd_ptr[PW-1:0]];

endmodule

// File: tb/tb_var_stats_stream.sv
// Directed bench for var_stats_stream (LANES=16, BEATS=4, FIFO_DEPTH=4) with hand-computed
// Q16.16 expectations; inputs change and outputs are sampled on the falling edge.
module tb_var_stats_stream;
  localparam int DATA_W     = 16;
  localparam int LANES      = 16;
  localparam int BEATS      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = LANES * DATA_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_err;
  logic [31:0]   out_mean;
  logic [31:0]   out_ex2;
  logic [31:0]   out_var;
  int            vectors = 0;
  int            miscompares = 0;
  int            vecs_sent = 0;

  var_stats_stream #(
    .DATA_W(DATA_W), .LANES(LANES), .BEATS(BEATS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_mean(out_mean),
    .out_ex2(out_ex2), .out_var(out_var), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] fill(input logic [15:0] a, input logic [15:0] b);
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*DATA_W +: DATA_W] = (k % 2 == 0) ? a : b;
    return d;
  endfunction

  function automatic logic [97:0] res(input logic [31:0] m, input logic [31:0] e,
                                      input logic [31:0] v, input logic er);
    return {1'b1, m, e, v, er};
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic last, output logic ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] a, input logic [15:0] b, input int nb,
                          input int last_at, output logic ok);
    logic bok;
    ok = 1'b1;
    for (int i = 0; i < nb; i++) begin
      send_beat(fill(a, b), (i == last_at), bok);
      ok &= bok;
    end
  endtask

  task automatic pop_result(output logic [97:0] r);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    r = {out_valid, out_mean, out_ex2, out_var, out_err};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({out_valid, out_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_flags: got valid/err=%b want 00", {out_valid, out_err});
    end
    vectors++;
    if ({out_mean, out_ex2, out_var} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {out_mean, out_ex2, out_var});
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_const;
    logic ok;
    logic [97:0] r;
    int cyc;
    send_vec(16'h0100, 16'h0100, 4, 3, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL const_accept: got ok=%b want 1", ok);
    end
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != 8) begin
      miscompares++;
      $display("FAIL const_latency: got %0d cycles want 8", cyc);
    end
    pop_result(r);
    vectors++;
    if (r !== res(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0)) begin
      miscompares++;
      $display("FAIL const_result: got %h want %h", r,
               res(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0));
    end
  endtask

  task automatic test_patterns;
    logic [15:0] pa [2];
    logic [15:0] pb [2];
    logic [97:0] exp_r [2];
    logic [97:0] r;
    logic ok;
    pa[0] = 16'h0200; pb[0] = 16'hFE00; exp_r[0] = res(32'h0, 32'h0004_0000, 32'h0004_0000, 1'b0);
    pa[1] = 16'h8000; pb[1] = 16'h8000; exp_r[1] = res(32'hFF80_0000, 32'h4000_0000, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      send_vec(pa[i], pb[i], 4, 3, ok);
      pop_result(r);
      vectors++;
      if (r !== exp_r[i]) begin
        miscompares++;
        $display("FAIL pattern%0d: got %h want %h", i, r, exp_r[i]);
      end
    end
  endtask

  task automatic test_framing;
    logic ok;
    logic [97:0] r;
    logic [97:0] exp_r [4];
    out_ready = 1'b0;
    send_vec(16'h0100, 16'h0100, 2, 1, ok);
    send_vec(16'h0200, 16'h0200, 4, 3, ok);
    send_vec(16'h0100, 16'h0100, 4, -1, ok);
    send_vec(16'h0200, 16'hFE00, 4, 3, ok);
    exp_r[0] = res(32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b1);
    exp_r[1] = res(32'h0002_0000, 32'h0004_0000, 32'h0, 1'b0);
    exp_r[2] = res(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    exp_r[3] = res(32'h0, 32'h0004_0000, 32'h0004_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pop_result(r);
      vectors++;
      if (r !== exp_r[i]) begin
        miscompares++;
        $display("FAIL framing%0d: got %h want %h", i, r, exp_r[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic ok;
    int n;
    logic [97:0] exp_r [3];
    exp_r[0] = res(32'h0000_4000, 32'h0000_4000, 32'h0000_3000, 1'b1);
    exp_r[1] = res(32'h0000_8000, 32'h0001_0000, 32'h0000_C000, 1'b1);
    exp_r[2] = res(32'h0000_C000, 32'h0002_4000, 32'h0001_B000, 1'b1);
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) send_beat(fill(16'(k * 256), 16'(k * 256)), 1'b1, ok);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({out_valid, out_mean, out_ex2, out_var, out_err} !== exp_r[i]) begin
        miscompares++;
        $display("FAIL b2b%0d: got %h want %h", i,
                 {out_valid, out_mean, out_ex2, out_var, out_err}, exp_r[i]);
      end
      @(negedge clk);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [97:0] r;
    int n;
    out_ready = 1'b0;
    vecs_sent = 0;
    fork
      begin
        logic ok;
        for (int v = 1; v <= 6; v++) begin
          send_vec(16'(v * 256), 16'(v * 256), 4, 3, ok);
          vecs_sent++;
        end
      end
      begin
        n = 0;
        while (vecs_sent < 4 && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (20) @(negedge clk);
        vectors++;
        if ({in_ready, vecs_sent == 4} !== 2'b01) begin
          miscompares++;
          $display("FAIL bp_stall: got in_ready=%b sent=%0d want in_ready=0 sent=4",
                   in_ready, vecs_sent);
        end
        for (int v = 1; v <= 6; v++) begin
          pop_result(r);
          vectors++;
          if (r !== res(32'(v << 16), 32'((v * v) << 16), 32'h0, 1'b0)) begin
            miscompares++;
            $display("FAIL bp_result%0d: got %h want %h", v, r,
                     res(32'(v << 16), 32'((v * v) << 16), 32'h0, 1'b0));
          end
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_extra: got out_valid=%b want 0", out_valid);
        end
      end
    join
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic [97:0] r;
    int n;
    out_ready = 1'b0;
    send_vec(16'h0100, 16'h0100, 4, 3, ok);
    send_vec(16'h0200, 16'h0200, 4, 3, ok);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    send_beat(fill(16'h0700, 16'h0700), 1'b0, ok);
    send_beat(fill(16'h0700, 16'h0700), 1'b0, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_mid: got valid/ready=%b want 01", {out_valid, in_ready});
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stale: got out_valid=%b want 0", out_valid);
    end
    for (int v = 3; v <= 6; v++) begin
      send_vec(16'(v * 256), 16'(v * 256), 4, 3, ok);
      vectors++;
      if (ok !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_credit%0d: got accepted=%b want 1", v, ok);
      end
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_full: got in_ready=%b want 0", in_ready);
    end
    for (int v = 3; v <= 6; v++) begin
      pop_result(r);
      vectors++;
      if (r !== res(32'(v << 16), 32'((v * v) << 16), 32'h0, 1'b0)) begin
        miscompares++;
        $display("FAIL rst_result%0d: got %h want %h", v, r,
                 res(32'(v << 16), 32'((v * v) << 16), 32'h0, 1'b0));
      end
    end
    repeat (15) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_residue: got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_const;
    test_patterns;
    test_framing;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/var_stats_stream.md
Name: var_stats_stream

Overview:
Streaming statistics engine that accepts a vector of N = LANES*BEATS signed Q8.8 samples over one or more beats. For each vector it returns the mean, E[x^2] and the variance (E[x^2] - mean^2) in Q16.16. It is the parametrised successor of the fixed 64-lane E[x^2] unit in the normalisation path. It adds multi-beat accumulation, signed mean, variance, a result FIFO and credit-based backpressure. All arithmetic is in-house RTL: no vendor multiplier or adder cores.

Parameters:
DATA_W, 16, sample width; signed Q8.8, fractional bits fixed at 8.
LANES, 16, samples per input beat; power of two, 1..64.
BEATS, 4, beats per vector; LANES*BEATS must be a power of two, 1..4096.
FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat ready.
in_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
in_last  in  1  marks the final beat of a vector.
out_valid  out  1  result valid.
out_ready  in  1  result ready.
out_mean  out  32  signed Q16.16 mean.
out_ex2  out  32  unsigned Q16.16 E[x^2].
out_var  out  32  unsigned Q16.16 variance.
out_err  out  1  vector framing error flag.

Behaviour:
- Reset: out_valid=0 and out_err=0; out_mean, out_ex2 and out_var are 0. FIFO is emptied, beat counter cleared, credits set to FIFO_DEPTH, all pipeline valids cleared. in_ready=1 in the cycle after rst deasserts.
- Reset mid-operation discards all partial sums, in-flight vectors and queued results. No stale result may appear after reset.
- Handshake: a beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready. Output data stays stable while out_valid && !out_ready.
- Credits: one credit is reserved when the first beat of a vector is accepted, and released when a result is popped.
  - in_ready = (credits > 0) || mid_vector.
  - A same-cycle reserve and release leaves the count unchanged.
  - The FIFO can never overflow.
- Framing: beat_cnt runs 0..BEATS-1. A vector closes on the accepted beat carrying in_last, or on beat BEATS-1, whichever comes first.
  - out_err=1 if in_last arrives before beat BEATS-1, or is absent on beat BEATS-1.
  - The result is still produced, using the same divisor N.
  - beat_cnt returns to 0 after a vector closes.
- Pipeline, per accepted beat:
  - S0: register sign-extended x and x*x. The square is unsigned, 2*DATA_W bits, Q16.16.
  - Tree: log2(LANES) registered adder stages over x, widths growing 1 bit per stage, and likewise over x^2.
  - ACC: add the beat sum into the accumulators. The accumulators clear on the first beat of each vector.
  - DIV: mean = (sum_x << 8) >>> log2(N), giving Q16.16 with arithmetic shift (floor). ex2 = sum_sq >> log2(N), truncated.
  - MUL: msq = (mean*mean) >> 16, a 64-bit product.
  - SUB: var = ex2 - msq, clamped to 0 if negative; the result is written to the FIFO.
- Latency: out_valid rises log2(LANES)+4 cycles after the acceptance cycle of a vector's closing beat, provided the FIFO is empty. For example, 8 cycles at LANES=16.
- Throughput: one beat per cycle while credits allow. Back-to-back vectors carry no bubble.
- FIFO: first-word fall-through, with outputs driven from the head entry. Results stay strictly in order. A simultaneous push and pop at occupancy 1 keeps out_valid high with no gap.
- Widths:
  - sum_x is DATA_W+log2(N) bits, signed.
  - sum_sq is 2*DATA_W+log2(N) bits, unsigned.
  - No intermediate overflow is permitted.

Test Plan:
- Constant 1.0: 64 samples of 0x0100 (LANES=16, BEATS=4, in_last on beat 3) -> mean=0x00010000, ex2=0x00010000, var=0, err=0, out_valid exactly 8 cycles after the last beat.
- Alternating +2.0/-2.0 (0x0200/0xFE00) -> mean=0, ex2=0x00040000, var=0x00040000.
- Extreme value, all 0x8000 (-128.0) -> mean=0xFF800000, ex2=0x40000000, var=0; checks no overflow in the square, tree or mean^2 paths.
- Backpressure with out_ready=0: send 6 back-to-back vectors -> in_ready drops after the 4th vector. Then raise out_ready -> 6 results emerge in order with no loss or duplication; also check the same-cycle push/pop edge.
- Framing errors: in_last on beat 1 -> err=1, and the next vector starts at beat 0. No in_last on beat 3 -> err=1, and the vector closes anyway.
- Reset: assert rst for 1 cycle mid-vector with 2 results queued -> out_valid=0 next cycle and credits=4. A following clean vector produces the correct result, and no residue from before the reset appears.
